updown_bounce_counter: RTL

Parametrised programmable counter with a chip-select register bus. It is the successor of the 8-bit up/down bounce counter: data width is configurable, separate read and write buses replace the bidirectional one, and it adds wrap modes, abort, a remaining-cycle readback and a busy flag. It sits on the local processor bus as a register-mapped peripheral and drives count, direction and end-of-cycle status to downstream logic.

---
 rtl/updown_counter_pkg.sv | 41 ++++
 rtl/counter_regfile.sv | 100 ++++++++++
 rtl/updown_bounce_counter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/updown_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : updown_counter_pkg
// Purpose  : Shared types and constants for the up/down bounce counter:
//            counting-mode enum, FSM state encoding, register addresses and
//            MODE register bit positions.
// Revision : 1.0  initial release
// ============================================================================
package updown_counter_pkg;

    // Counting mode held in MODE[1:0]; the reserved code behaves as bounce.
    typedef enum logic [1:0] {
        c_MODE_BOUNCE    = 2'b00,
        c_MODE_UP_WRAP   = 2'b01,
        c_MODE_DOWN_WRAP = 2'b10,
        c_MODE_RESERVED  = 2'b11
    } mode_e;

    // Counter FSM; in bounce mode the state names the direction of the next step.
    typedef enum logic [1:0] {
        c_ST_IDLE   = 2'b00,
        c_ST_UP     = 2'b01,
        c_ST_DOWN   = 2'b10,
        c_ST_RETURN = 2'b11
    } state_e;

    // Register map
    localparam logic [2:0] c_ADDR_PLR    = 3'd0;
    localparam logic [2:0] c_ADDR_ULR    = 3'd1;
    localparam logic [2:0] c_ADDR_LLR    = 3'd2;
    localparam logic [2:0] c_ADDR_CCR    = 3'd3;
    localparam logic [2:0] c_ADDR_MODE   = 3'd4;
    localparam logic [2:0] c_ADDR_STATUS = 3'd5;

    // MODE register fields
    localparam int c_MODE_SEL_LSB   = 0;
    localparam int c_MODE_SEL_MSB   = 1;
    localparam int c_MODE_ABORT_BIT = 2;

endpackage : updown_counter_pkg
`default_nettype wire

// File: rtl/counter_regfile.sv
`default_nettype none
// ============================================================================
// Module   : counter_regfile
// Purpose  : Programming registers (PLR, ULR, LLR, CCR, MODE) of the up/down
//            bounce counter, with bus write gating, the combinational read
//            mux and the limit-consistency check.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            i_ncs/i_nwr/i_nrd, i_addr, i_din, o_dout - register bus
//            i_busy          - counter running; blocks all writes but abort
//            i_remaining     - remaining-cycle count for STATUS readback
//            o_plr/o_ulr/o_llr/o_ccr/o_mode - register contents
//            o_abort         - MODE write with the abort bit set (this clock)
//            o_err           - limit configuration invalid
// Revision : 1.0  initial release
// ============================================================================
module counter_regfile
    import updown_counter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CCR_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_ncs,
    input  logic                 i_nwr,
    input  logic                 i_nrd,
    input  logic [2:0]           i_addr,
    input  logic [WIDTH-1:0]     i_din,
    output logic [WIDTH-1:0]     o_dout,
    input  logic                 i_busy,
    input  logic [CCR_WIDTH-1:0] i_remaining,
    output logic [WIDTH-1:0]     o_plr,
    output logic [WIDTH-1:0]     o_ulr,
    output logic [WIDTH-1:0]     o_llr,
    output logic [CCR_WIDTH-1:0] o_ccr,
    output mode_e                o_mode,
    output logic                 o_abort,
    output logic                 o_err
);

    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    logic [WIDTH-1:0]     r_plr;
    logic [WIDTH-1:0]     r_ulr;
    logic [WIDTH-1:0]     r_llr;
    logic [CCR_WIDTH-1:0] r_ccr;
    mode_e                r_mode;

    logic w_wr;
    logic w_wr_en;

    // A cycle with both strobes low is treated as a read, never a write.
    assign w_wr    = ~i_ncs & ~i_nwr & i_nrd;
    assign o_abort = w_wr && (i_addr == c_ADDR_MODE) && i_din[c_MODE_ABORT_BIT];
    // The abort write is the only one that may land while a run is active.
    assign w_wr_en = w_wr & (~i_busy | o_abort);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_plr  <= c_ONE;
            r_ulr  <= '1;
            r_llr  <= '0;
            r_ccr  <= '0;
            r_mode <= c_MODE_BOUNCE;
        end else if (w_wr_en) begin
            case (i_addr)
                c_ADDR_PLR:  r_plr  <= i_din;
                c_ADDR_ULR:  r_ulr  <= i_din;
                c_ADDR_LLR:  r_llr  <= i_din;
                c_ADDR_CCR:  r_ccr  <= CCR_WIDTH'(i_din);
                c_ADDR_MODE: r_mode <= mode_e'(i_din[c_MODE_SEL_MSB:c_MODE_SEL_LSB]);
                default:     ;
            endcase
        end
    end

    always_comb begin
        o_dout = '0;
        if (!i_ncs && !i_nrd) begin
            case (i_addr)
                c_ADDR_PLR:    o_dout = r_plr;
                c_ADDR_ULR:    o_dout = r_ulr;
                c_ADDR_LLR:    o_dout = r_llr;
                c_ADDR_CCR:    o_dout = WIDTH'(r_ccr);
                c_ADDR_MODE:   o_dout = WIDTH'(r_mode);       // abort bit is never stored
                c_ADDR_STATUS: o_dout = WIDTH'(i_remaining);
                default:       o_dout = '0;
            endcase
        end
    end

    assign o_err  = (r_plr < r_llr) || (r_plr > r_ulr) || (r_llr > r_ulr);
    assign o_plr  = r_plr;
    assign o_ulr  = r_ulr;
    assign o_llr  = r_llr;
    assign o_ccr  = r_ccr;
    assign o_mode = r_mode;

endmodule : counter_regfile
`default_nettype wire

// File: rtl/updown_bounce_counter.sv
`default_nettype none
// ============================================================================
// Module   : updown_bounce_counter
// Purpose  : Register-mapped programmable counter. Runs CCR cycles between
//            the lower and upper limits in bounce, up-wrap or down-wrap mode,
//            starting and finishing at the preload value.
// Ports    : clk_in, reset_in (async, active-low)
//            ncs_in, nwr_in, nrd_in, addr_in, din_in, dout_out - register bus
//            start_in  - start request (rising edge)
//            count_out, dir_out, busy_out, err_out, ec_out - status outputs
// Revision : 1.0  initial release
// ============================================================================
module updown_bounce_counter
    import updown_counter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CCR_WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             ncs_in,
    input  logic             nwr_in,
    input  logic             nrd_in,
    input  logic [2:0]       addr_in,
    input  logic [WIDTH-1:0] din_in,
    output logic [WIDTH-1:0] dout_out,
    input  logic             start_in,
    output logic [WIDTH-1:0] count_out,
    output logic             dir_out,
    output logic             busy_out,
    output logic             err_out,
    output logic             ec_out
);

    localparam logic [WIDTH-1:0]     c_ONE     = WIDTH'(1);
    localparam logic [CCR_WIDTH-1:0] c_REM_ONE = CCR_WIDTH'(1);

    logic [WIDTH-1:0]     w_plr;
    logic [WIDTH-1:0]     w_ulr;
    logic [WIDTH-1:0]     w_llr;
    logic [CCR_WIDTH-1:0] w_ccr;
    mode_e                w_mode;
    logic                 w_abort;
    logic                 w_err;

    logic                 r_start_q;
    state_e               r_state;
    logic [WIDTH-1:0]     r_count;
    logic                 r_dir;
    logic                 r_busy;
    logic                 r_ec;
    logic [CCR_WIDTH-1:0] r_remaining;

    logic                 w_start_edge;
    logic                 w_start_ok;
    logic                 w_all_eq;
    state_e               w_start_state;
    logic [WIDTH-1:0]     w_step_count;
    state_e               w_step_state;
    logic                 w_cycle_done;

    counter_regfile #(
        .WIDTH     (WIDTH),
        .CCR_WIDTH (CCR_WIDTH)
    ) u_regfile (
        .clk         (clk_in),
        .rst_n       (reset_in),
        .i_ncs       (ncs_in),
        .i_nwr       (nwr_in),
        .i_nrd       (nrd_in),
        .i_addr      (addr_in),
        .i_din       (din_in),
        .o_dout      (dout_out),
        .i_busy      (r_busy),
        .i_remaining (r_remaining),
        .o_plr       (w_plr),
        .o_ulr       (w_ulr),
        .o_llr       (w_llr),
        .o_ccr       (w_ccr),
        .o_mode      (w_mode),
        .o_abort     (w_abort),
        .o_err       (w_err)
    );

    assign w_start_edge = start_in & ~r_start_q;
    assign w_start_ok   = w_start_edge & ~ncs_in & ~r_busy & ~w_err & (w_ccr != '0);
    assign w_all_eq     = (w_plr == w_ulr) && (w_plr == w_llr);

    // First state of a run. Degenerate all-equal limits always report "up".
    always_comb begin
        w_start_state = c_ST_UP;
        if (!w_all_eq) begin
            if (w_mode == c_MODE_DOWN_WRAP) begin
                w_start_state = c_ST_DOWN;
            end else if ((w_mode != c_MODE_UP_WRAP) && (w_plr == w_ulr)) begin
                w_start_state = c_ST_DOWN;
            end
        end
    end

    // One counting step. Turn-around decisions are taken on arrival at a
    // limit, so every step moves the count by exactly one.
    always_comb begin
        w_step_count = r_count;
        w_step_state = r_state;
        w_cycle_done = 1'b0;
        if (w_all_eq) begin
            w_cycle_done = 1'b1;
        end else begin
            case (w_mode)
                c_MODE_UP_WRAP: begin
                    w_step_count = (r_count == w_ulr) ? w_llr : r_count + c_ONE;
                    w_cycle_done = (w_step_count == w_plr);
                end
                c_MODE_DOWN_WRAP: begin
                    w_step_count = (r_count == w_llr) ? w_ulr : r_count - c_ONE;
                    w_cycle_done = (w_step_count == w_plr);
                end
                default: begin
                    case (r_state)
                        c_ST_UP: begin
                            w_step_count = r_count + c_ONE;
                            if (w_step_count == w_ulr) begin
                                w_step_state = c_ST_DOWN;
                            end
                        end
                        c_ST_DOWN: begin
                            w_step_count = r_count - c_ONE;
                            if (w_step_count == w_llr) begin
                                // Preload at the lower limit: no return leg.
                                if (w_plr == w_llr) begin
                                    w_cycle_done = 1'b1;
                                    w_step_state = c_ST_UP;
                                end else begin
                                    w_step_state = c_ST_RETURN;
                                end
                            end
                        end
                        c_ST_RETURN: begin
                            w_step_count = r_count + c_ONE;
                            if (w_step_count == w_plr) begin
                                w_cycle_done = 1'b1;
                                w_step_state = (w_plr == w_ulr) ? c_ST_DOWN : c_ST_UP;
                            end
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_start_q   <= 1'b0;
            r_state     <= c_ST_IDLE;
            r_count     <= '0;
            r_dir       <= 1'b0;
            r_busy      <= 1'b0;
            r_ec        <= 1'b0;
            r_remaining <= '0;
        end else begin
            // The edge detector keeps sampling while deselected so that an
            // edge seen during ncs_in=1 is consumed rather than deferred.
            r_start_q <= start_in;
            r_ec      <= 1'b0;
            if (w_abort) begin
                r_state     <= c_ST_IDLE;
                r_busy      <= 1'b0;
                r_remaining <= '0;
            end else if (!ncs_in) begin
                if (r_busy) begin
                    r_count <= w_step_count;
                    if (w_cycle_done && (r_remaining == c_REM_ONE)) begin
                        r_state     <= c_ST_IDLE;
                        r_busy      <= 1'b0;
                        r_remaining <= '0;
                        r_ec        <= 1'b1;
                    end else begin
                        r_state <= w_step_state;
                        r_dir   <= (w_step_state != c_ST_DOWN);
                        if (w_cycle_done) begin
                            r_remaining <= r_remaining - c_REM_ONE;
                        end
                    end
                end else if (w_start_ok) begin
                    r_count     <= w_plr;
                    r_busy      <= 1'b1;
                    r_remaining <= w_ccr;
                    r_state     <= w_start_state;
                    r_dir       <= (w_start_state != c_ST_DOWN);
                end
            end
        end
    end

    assign count_out = r_count;
    assign dir_out   = r_dir;
    assign busy_out  = r_busy;
    assign err_out   = w_err;
    assign ec_out    = r_ec;

endmodule : updown_bounce_counter
`default_nettype wire
